// File: rtl/fpmul_param.sv
// Multi-cycle IEEE-754-style multiplier with EXP_W/MAN_W fields, four rounding modes and flush-to-zero.
// Start/Done handshake: 6 cycles to Done for normal operands, 3 for special cases; Start ignored while Busy.
module fpmul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Start,
  input  logic [1:0]             Rmode,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   Busy,
  output logic                   Done,
  output logic [EXP_W+MAN_W:0]   P,
  output logic                   OF,
  output logic                   UF,
  output logic                   NaNF,
  output logic                   InfF,
  output logic                   DNF,
  output logic                   ZF,
  output logic                   NX
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [XW-1:0]    BIAS     = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0]    EXP_OVF  = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLASS, S_MULT, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  typedef enum logic [1:0] {C_NORM, C_ZERO, C_INF, C_NAN} cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [W-1:0]     a_q, b_q;
  logic [1:0]       rm_q;
  logic             sign_q, dnf_q, g_q, s_q;
  logic [PW-1:0]    prod_q;
  logic [XW-1:0]    exp_q;
  logic [MAN_W:0]   sig_q;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_dn, b_dn;

  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign fa = a_q[MAN_W-1:0];
  assign fb = b_q[MAN_W-1:0];

  // Denormals (exp=0, frac!=0) are classified as zero.
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_dn   = a_zero && (fa != '0);
  assign b_dn   = b_zero && (fb != '0);

  always_comb begin
    cls_d = C_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      cls_d = C_NAN;
    else if (a_inf || b_inf)
      cls_d = C_INF;
    else if (a_zero || b_zero)
      cls_d = C_ZERO;
  end

  logic [MAN_W:0]  n_sig;
  logic            n_g, n_s;
  logic [XW-1:0]   n_exp;

  always_comb begin
    n_sig = prod_q[PW-2:MAN_W];
    n_g   = prod_q[MAN_W-1];
    n_s   = |prod_q[MAN_W-2:0];
    n_exp = exp_q;
    if (prod_q[PW-1]) begin
      n_sig = prod_q[PW-1:MAN_W+1];
      n_g   = prod_q[MAN_W];
      n_s   = |prod_q[MAN_W-1:0];
      n_exp = exp_q + XW'(1);
    end
  end

  logic            rnd_up;
  logic [MAN_W+1:0] r_sum;

  always_comb begin
    rnd_up = 1'b0;
    case (rm_q)
      2'b00:   rnd_up = g_q & (s_q | sig_q[0]);
      2'b01:   rnd_up = 1'b0;
      2'b10:   rnd_up = (g_q | s_q) & ~sign_q;
      default: rnd_up = (g_q | s_q) & sign_q;
    endcase
  end

  assign r_sum = {1'b0, sig_q} + {{(MAN_W+1){1'b0}}, rnd_up};

  logic [W-1:0] pk_p;
  logic         pk_of, pk_uf, pk_nan, pk_inf, pk_z, pk_nx, to_inf;

  assign to_inf = (rm_q == 2'b00) || (rm_q == 2'b10 && !sign_q) || (rm_q == 2'b11 && sign_q);

  always_comb begin
    pk_p   = '0;
    pk_of  = 1'b0;
    pk_uf  = 1'b0;
    pk_nan = 1'b0;
    pk_inf = 1'b0;
    pk_z   = 1'b0;
    pk_nx  = 1'b0;
    case (cls_q)
      C_NAN: begin
        pk_p   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        pk_nan = 1'b1;
      end
      C_INF: begin
        pk_p   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        pk_inf = 1'b1;
      end
      C_ZERO: begin
        pk_p = {sign_q, {(W-1){1'b0}}};
        pk_z = 1'b1;
      end
      default: begin
        if ($signed(exp_q) >= $signed(EXP_OVF)) begin
          pk_of = 1'b1;
          pk_nx = 1'b1;
          if (to_inf) begin
            pk_p   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            pk_inf = 1'b1;
          end else begin
            pk_p = {sign_q, EXP_MAXF, {MAN_W{1'b1}}};
          end
        end else if (exp_q[XW-1] || exp_q == '0) begin
          pk_p  = {sign_q, {(W-1){1'b0}}};
          pk_uf = 1'b1;
          pk_z  = 1'b1;
          pk_nx = 1'b1;
        end else begin
          pk_p  = {sign_q, exp_q[EXP_W-1:0], sig_q[MAN_W-1:0]};
          pk_nx = g_q | s_q;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_CLASS;
      S_CLASS: state_d = (cls_d == C_NORM) ? S_MULT : S_PACK;
      S_MULT:  state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_PACK;
      S_PACK:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = (state_q == S_DONE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      rm_q   <= '0;
      cls_q  <= C_NORM;
      sign_q <= 1'b0;
      dnf_q  <= 1'b0;
      prod_q <= '0;
      exp_q  <= '0;
      sig_q  <= '0;
      g_q    <= 1'b0;
      s_q    <= 1'b0;
      P      <= '0;
      OF     <= 1'b0;
      UF     <= 1'b0;
      NaNF   <= 1'b0;
      InfF   <= 1'b0;
      DNF    <= 1'b0;
      ZF     <= 1'b0;
      NX     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (Start) begin
          a_q  <= A;
          b_q  <= B;
          rm_q <= Rmode;
          P    <= '0;
          OF   <= 1'b0;
          UF   <= 1'b0;
          NaNF <= 1'b0;
          InfF <= 1'b0;
          DNF  <= 1'b0;
          ZF   <= 1'b0;
          NX   <= 1'b0;
        end
        S_CLASS: begin
          cls_q  <= cls_d;
          sign_q <= a_q[W-1] ^ b_q[W-1];
          dnf_q  <= a_dn | b_dn;
        end
        S_MULT: begin
          prod_q <= {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};
          exp_q  <= {2'b00, ea} + {2'b00, eb} - BIAS;
        end
        S_NORM: begin
          sig_q <= n_sig;
          g_q   <= n_g;
          s_q   <= n_s;
          exp_q <= n_exp;
        end
        S_ROUND: begin
          // Rounding carry-out turns 1.11..1 into 10.0..0; renormalise.
          if (r_sum[MAN_W+1]) begin
            sig_q <= r_sum[MAN_W+1:1];
            exp_q <= exp_q + XW'(1);
          end else begin
            sig_q <= r_sum[MAN_W:0];
          end
        end
        S_PACK: begin
          P    <= pk_p;
          OF   <= pk_of;
          UF   <= pk_uf;
          NaNF <= pk_nan;
          InfF <= pk_inf;
          DNF  <= dnf_q;
          ZF   <= pk_z;
          NX   <= pk_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_param.sv
// Bench for fpmul_param: directed table, handshake corner sequences and random ops vs an integer-arithmetic model.
module tb_fpmul_param;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst_n;
  logic        s32, s16;
  logic [1:0]  rm32, rm16;
  logic [31:0] a32, b32, p32;
  logic [15:0] a16, b16, p16;
  logic        busy32, done32, of32, uf32, nan32, inf32, dn32, z32, nx32;
  logic        busy16, done16, of16, uf16, nan16, inf16, dn16, z16, nx16;

  fpmul_param u32 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(s32), .Rmode(rm32), .A(a32), .B(b32),
    .Busy(busy32), .Done(done32), .P(p32), .OF(of32), .UF(uf32), .NaNF(nan32),
    .InfF(inf32), .DNF(dn32), .ZF(z32), .NX(nx32)
  );

  fpmul_param #(.EXP_W(5), .MAN_W(10)) u16 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(s16), .Rmode(rm16), .A(a16), .B(b16),
    .Busy(busy16), .Done(done16), .P(p16), .OF(of16), .UF(uf16), .NaNF(nan16),
    .InfF(inf16), .DNF(dn16), .ZF(z16), .NX(nx16)
  );

  int checks = 0;
  int errors = 0;

  // Flag vector layout: {OF, UF, NaNF, InfF, DNF, ZF, NX}
  typedef struct {
    logic [31:0] p;
    logic [6:0]  fl;
    int          lat;
  } res_t;

  typedef struct {
    bit          h;
    logic [31:0] a, b;
    logic [1:0]  rm;
    logic [31:0] p;
    logic [6:0]  fl;
    int          lat;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic logic [6:0] flv(input bit h);
    return h ? {of16, uf16, nan16, inf16, dn16, z16, nx16}
             : {of32, uf32, nan32, inf32, dn32, z32, nx32};
  endfunction
  function automatic logic [31:0] pv(input bit h);
    return h ? {16'h0, p16} : p32;
  endfunction
  function automatic logic bsy(input bit h);
    return h ? busy16 : busy32;
  endfunction
  function automatic logic dne(input bit h);
    return h ? done16 : done32;
  endfunction

  task automatic drive(input bit h, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] rm);
    if (h) begin
      s16 = st; a16 = a[15:0]; b16 = b[15:0]; rm16 = rm;
    end else begin
      s32 = st; a32 = a; b32 = b; rm32 = rm;
    end
  endtask

  // Plain-arithmetic reference: exact integer product, rounded by comparing the remainder to one half ulp.
  function automatic res_t model(input int ew, input int mw, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] rm);
    res_t r;
    int ones, bias, ea, eb, e, sh;
    longint unsigned av, bv, mm, fa, fb, prod, q, rem, half, sgn;
    bit s, an, bn, ai, bi, az, bz, inexact, up;
    av   = 64'(a);
    bv   = 64'(b);
    ones = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    mm   = (64'd1 << mw) - 1;
    ea   = int'(av >> mw) & ones;
    eb   = int'(bv >> mw) & ones;
    fa   = av & mm;
    fb   = bv & mm;
    s    = av[ew+mw] ^ bv[ew+mw];
    sgn  = 64'(s) << (ew + mw);
    an = (ea == ones) && (fa != 0);
    bn = (eb == ones) && (fb != 0);
    ai = (ea == ones) && (fa == 0);
    bi = (eb == ones) && (fb == 0);
    az = (ea == 0);
    bz = (eb == 0);
    r.p = '0;
    r.fl = '0;
    r.lat = 3;
    r.fl[2] = (az && fa != 0) || (bz && fb != 0);
    if (an || bn || (ai && bz) || (bi && az)) begin
      r.p = 32'((64'(ones) << mw) | (64'd1 << (mw - 1)));
      r.fl[4] = 1'b1;
    end else if (ai || bi) begin
      r.p = 32'(sgn | (64'(ones) << mw));
      r.fl[3] = 1'b1;
    end else if (az || bz) begin
      r.p = 32'(sgn);
      r.fl[1] = 1'b1;
    end else begin
      r.lat = 6;
      prod = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
      e  = ea + eb - bias;
      sh = mw;
      if ((prod >> (2 * mw + 1)) != 0) begin
        sh = mw + 1;
        e++;
      end
      q       = prod >> sh;
      rem     = prod & ((64'd1 << sh) - 1);
      half    = 64'd1 << (sh - 1);
      inexact = (rem != 0);
      case (rm)
        2'b00:   up = (rem > half) || (rem == half && q[0]);
        2'b01:   up = 1'b0;
        2'b10:   up = inexact && !s;
        default: up = inexact && s;
      endcase
      q = q + 64'(up);
      if (q == (64'd1 << (mw + 1))) begin
        q = q >> 1;
        e++;
      end
      if (e >= ones) begin
        r.fl[6] = 1'b1;
        r.fl[0] = 1'b1;
        if (rm == 2'b00 || (rm == 2'b10 && !s) || (rm == 2'b11 && s)) begin
          r.p = 32'(sgn | (64'(ones) << mw));
          r.fl[3] = 1'b1;
        end else begin
          r.p = 32'(sgn | (64'(ones - 1) << mw) | mm);
        end
      end else if (e <= 0) begin
        r.p = 32'(sgn);
        r.fl[5] = 1'b1;
        r.fl[1] = 1'b1;
        r.fl[0] = 1'b1;
      end else begin
        r.p = 32'(sgn | (64'(e) << mw) | (q & mm));
        r.fl[0] = inexact;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] gen(input int ew, input int mw);
    int ones, bias, e, sel;
    longint unsigned f, mm;
    bit s;
    ones = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    mm   = (64'd1 << mw) - 1;
    f    = {$urandom, $urandom} & mm;
    s    = 1'($urandom_range(0, 1));
    sel  = int'($urandom_range(0, 7));
    if (sel <= 3)      e = int'($urandom_range(bias - mw, bias + mw));
    else if (sel == 4) e = int'($urandom_range(0, ones));
    else if (sel == 5) e = (bias + ones) / 2 + int'($urandom_range(0, 3));
    else if (sel == 6) e = bias / 2 + int'($urandom_range(1, 3));
    else begin
      e = ($urandom_range(0, 1) != 0) ? ones : 0;
      if ($urandom_range(0, 1) != 0) f = 0;
    end
    if ($urandom_range(0, 3) == 0) f = f & (mm << (mw / 2)) & mm;
    return 32'((64'(s) << (ew + mw)) | (64'(e) << mw) | f);
  endfunction

  task automatic run_op(input bit h, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        input logic [31:0] ep, input logic [6:0] ef, input int el, input string nm);
    bit busy_ok;
    int got;
    @(negedge Clk);
    drive(h, 1'b1, a, b, rm);
    @(posedge Clk);
    #1 drive(h, 1'b0, a, b, rm);
    busy_ok = 1'b1;
    got = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (i == 1) chk({nm, ".clr"}, {25'h0, pv(h), flv(h)}, 64'h0);
      if (!bsy(h)) busy_ok = 1'b0;
      if (dne(h)) begin
        got = i;
        break;
      end
    end
    chk({nm, ".lat"}, 64'(got), 64'(el));
    chk({nm, ".busy"}, 64'(busy_ok), 64'd1);
    chk({nm, ".p"}, 64'(pv(h)), 64'(ep));
    chk({nm, ".flags"}, 64'(flv(h)), 64'(ef));
    @(negedge Clk);
    chk({nm, ".hold"}, {23'h0, dne(h), bsy(h), pv(h), flv(h)}, {25'h0, ep, ef});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t tbl[$];
  res_t r;
  int   cnt, first;

  initial begin
    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    repeat (3) @(negedge Clk);
    chk("reset32", {30'h0, busy32, done32, p32, flv(1'b0)}, 64'h0);
    chk("reset16", {46'h0, busy16, done16, p16, flv(1'b1)}, 64'h0);
    Rst_n = 1'b1;

    tbl.push_back('{0, 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 7'b0000000, 6, "mul1p5x2"});
    tbl.push_back('{0, 32'h7FC00000, 32'h3F800000, 2'b00, 32'h7FC00000, 7'b0010000, 3, "nan_in"});
    tbl.push_back('{0, 32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 7'b0010000, 3, "inf_x_zero"});
    tbl.push_back('{0, 32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 7'b1001001, 6, "ovf_rne"});
    tbl.push_back('{0, 32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, 7'b1000001, 6, "ovf_rtz"});
    tbl.push_back('{0, 32'h7F000000, 32'h7F000000, 2'b11, 32'h7F7FFFFF, 7'b1000001, 6, "ovf_ninf_pos"});
    tbl.push_back('{0, 32'hFF000000, 32'h7F000000, 2'b11, 32'hFF800000, 7'b1001001, 6, "ovf_ninf_neg"});
    tbl.push_back('{0, 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 7'b0000001, 6, "nx_rne"});
    tbl.push_back('{0, 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 7'b0000001, 6, "nx_pinf"});
    tbl.push_back('{0, 32'h00800000, 32'h00800000, 2'b00, 32'h00000000, 7'b0100011, 6, "underflow"});
    tbl.push_back('{0, 32'h00000001, 32'h3F800000, 2'b00, 32'h00000000, 7'b0000110, 3, "denorm"});
    tbl.push_back('{0, 32'hC0000000, 32'h3FC00000, 2'b00, 32'hC0400000, 7'b0000000, 6, "neg_mul"});
    tbl.push_back('{0, 32'h7F800000, 32'h40000000, 2'b00, 32'h7F800000, 7'b0001000, 3, "inf_x_two"});
    tbl.push_back('{0, 32'h80000000, 32'h40A00000, 2'b00, 32'h80000000, 7'b0000010, 3, "negzero"});
    tbl.push_back('{1, 32'h3C00, 32'h4000, 2'b00, 32'h4000, 7'b0000000, 6, "h_one_x_two"});
    tbl.push_back('{1, 32'h7800, 32'h7800, 2'b00, 32'h7C00, 7'b1001001, 6, "h_ovf_rne"});
    tbl.push_back('{1, 32'h7800, 32'h7800, 2'b01, 32'h7BFF, 7'b1000001, 6, "h_ovf_rtz"});
    tbl.push_back('{1, 32'h7E00, 32'h3C00, 2'b00, 32'h7E00, 7'b0010000, 3, "h_nan"});

    foreach (tbl[i])
      run_op(tbl[i].h, tbl[i].a, tbl[i].b, tbl[i].rm, tbl[i].p, tbl[i].fl, tbl[i].lat, tbl[i].nm);

    // Start pulsed again while busy must be ignored.
    @(negedge Clk);
    drive(1'b0, 1'b1, 32'h3FC00000, 32'h40000000, 2'b00);
    @(posedge Clk);
    #1 drive(1'b0, 1'b0, 32'h3FC00000, 32'h40000000, 2'b00);
    cnt = 0;
    first = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge Clk);
      if (i == 2) drive(1'b0, 1'b1, 32'h40400000, 32'h40400000, 2'b00);
      if (i == 3) drive(1'b0, 1'b0, 32'h40400000, 32'h40400000, 2'b00);
      if (done32) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("busy_start.ndone", 64'(cnt), 64'd1);
    chk("busy_start.lat", 64'(first), 64'd6);
    chk("busy_start.p", 64'(p32), 64'h40400000);

    // Reset mid-operation aborts with no Done.
    @(negedge Clk);
    drive(1'b0, 1'b1, 32'h3FC00000, 32'h40000000, 2'b00);
    @(posedge Clk);
    #1 drive(1'b0, 1'b0, 32'h3FC00000, 32'h40000000, 2'b00);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    #1 chk("midreset.outs", {30'h0, busy32, done32, p32, flv(1'b0)}, 64'h0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (done32 || busy32) cnt++;
    end
    chk("midreset.quiet", 64'(cnt), 64'd0);
    run_op(1'b0, 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 7'b0, 6, "after_reset");

    // Start in the DONE cycle is ignored; held into the next IDLE cycle it is accepted.
    @(negedge Clk);
    drive(1'b0, 1'b1, 32'h3F800001, 32'h3F800001, 2'b00);
    @(posedge Clk);
    #1 drive(1'b0, 1'b0, 32'h3F800001, 32'h3F800001, 2'b00);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (done32) begin
        first = i;
        break;
      end
    end
    chk("done_start.lat1", 64'(first), 64'd6);
    chk("done_start.p1", 64'(p32), 64'h3F800002);
    drive(1'b0, 1'b1, 32'h3FC00000, 32'h40000000, 2'b00);
    @(posedge Clk);
    @(negedge Clk);
    chk("done_start.ignored", {62'h0, busy32, done32}, 64'h0);
    @(posedge Clk);
    #1 drive(1'b0, 1'b0, 32'h3FC00000, 32'h40000000, 2'b00);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (done32) begin
        first = i;
        break;
      end
    end
    chk("done_start.lat2", 64'(first), 64'd6);
    chk("done_start.p2", 64'(p32), 64'h40400000);

    for (int i = 0; i < 160; i++) begin
      bit h;
      logic [31:0] a, b;
      logic [1:0] rm;
      h  = (i % 4 == 3);
      a  = h ? gen(5, 10) : gen(8, 23);
      b  = h ? gen(5, 10) : gen(8, 23);
      rm = 2'($urandom_range(0, 3));
      r  = h ? model(5, 10, a, b, rm) : model(8, 23, a, b, rm);
      run_op(h, a, b, rm, r.p, r.fl, r.lat, $sformatf("rnd%0d_%h_%h_m%0d", i, a, b, rm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
